// File: rtl/serdesphy_pll_pkg.sv
// Shared types and default constants for the PLL lock monitor: FSM states,
// frequency-error sign codes and the nominal 24 MHz / fb=ref/8 window setup.
package serdesphy_pll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SETTLE  = 2'b01,
        ST_MEASURE = 2'b10
    } mon_state_e;

    typedef enum logic [1:0] {
        ERR_ON_TARGET = 2'b00,
        ERR_FAST      = 2'b01,
        ERR_SLOW      = 2'b10
    } err_sign_e;

    localparam int unsigned DEF_WINDOW_CYCLES   = 240;
    localparam int unsigned DEF_EXP_EDGES       = 30;
    localparam int unsigned DEF_TOL             = 1;
    localparam int unsigned DEF_LOCK_WINDOWS    = 4;
    localparam int unsigned DEF_SETTLE_CYCLES   = 48;
    localparam int unsigned DEF_VCO_MIN_EDGES   = 15;
    localparam int unsigned DEF_VCO_MAX_EDGES   = 45;
    localparam int unsigned DEF_CP_RAIL_WINDOWS = 3;

    // Sign classification of a 9-bit two's-complement count error.
    function automatic err_sign_e classify_err(input logic [8:0] err);
        if (err == 9'd0)
            return ERR_ON_TARGET;
        else if (err[8])
            return ERR_SLOW;
        else
            return ERR_FAST;
    endfunction

endpackage

// File: rtl/serdesphy_pll_lock_monitor_if.sv
// Controller <-> lock monitor bundle: PLL controls in one direction, raw
// lock / range / health status and the frozen trim snapshot in the other.
interface serdesphy_pll_lock_monitor_if;

    logic       pll_enable;
    logic       pll_reset_n;
    logic       pll_bypass_en;
    logic       pll_iso_n;
    logic [3:0] pll_vco_trim;
    logic [1:0] pll_cp_current;

    logic       pll_lock_raw;
    logic       pll_vco_ok;
    logic       pll_cp_ok;
    logic [7:0] freq_count;
    logic [1:0] freq_err_sign;
    logic [3:0] freq_status_trim;

    modport master (
        output pll_enable, pll_reset_n, pll_bypass_en, pll_iso_n,
               pll_vco_trim, pll_cp_current,
        input  pll_lock_raw, pll_vco_ok, pll_cp_ok, freq_count,
               freq_err_sign, freq_status_trim
    );

    modport slave (
        input  pll_enable, pll_reset_n, pll_bypass_en, pll_iso_n,
               pll_vco_trim, pll_cp_current,
        output pll_lock_raw, pll_vco_ok, pll_cp_ok, freq_count,
               freq_err_sign, freq_status_trim
    );

endinterface

// File: rtl/serdesphy_sync_edge.sv
// Two-flop synchronizer with rising-edge pulse for asynchronous analog status
// inputs; an input edge becomes a one-cycle pulse consumed on the 3rd clock.
module serdesphy_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic [2:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst)
            sync_q <= '0;
        else
            sync_q <= {sync_q[1:0], async_in};
    end

    assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/serdesphy_pll_lock_monitor.sv
// PLL lock detector: counts synchronized feedback edges per reference window
// and derives raw lock, VCO range and charge-pump health. Optional lock
// hysteresis is enabled by defining PLL_LOCK_MON_HYST_EN.
module serdesphy_pll_lock_monitor
    import serdesphy_pll_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES   = DEF_WINDOW_CYCLES,
    parameter int unsigned EXP_EDGES       = DEF_EXP_EDGES,
    parameter int unsigned TOL             = DEF_TOL,
    parameter int unsigned LOCK_WINDOWS    = DEF_LOCK_WINDOWS,
    parameter int unsigned SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
    parameter int unsigned VCO_MIN_EDGES   = DEF_VCO_MIN_EDGES,
    parameter int unsigned VCO_MAX_EDGES   = DEF_VCO_MAX_EDGES,
    parameter int unsigned CP_RAIL_WINDOWS = DEF_CP_RAIL_WINDOWS
) (
    input  logic                         clk_ref_24m,
    input  logic                         rst,
    input  logic                         fb_clk_div,
    serdesphy_pll_lock_monitor_if.slave  pll
);

    localparam int unsigned WIN_W  = $clog2(WINDOW_CYCLES);
    localparam int unsigned SET_W  = $clog2(SETTLE_CYCLES);
    localparam int unsigned GOOD_W = $clog2(LOCK_WINDOWS + 1);
    localparam int unsigned RAIL_W = $clog2(CP_RAIL_WINDOWS + 1);

    mon_state_e        state_q, state_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [7:0]        edge_q, edge_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [RAIL_W-1:0] rail_q, rail_d;
    logic              lock_q, lock_d;
    logic              vco_q, vco_d;
    logic              cp_q, cp_d;
    logic [7:0]        count_q, count_d;
    err_sign_e         sign_q, sign_d;
    logic [3:0]        trim_q, trim_d;
`ifdef PLL_LOCK_MON_HYST_EN
    logic [1:0]        bad_q, bad_d;
`endif

    logic       run;
    logic       fb_rise;
    logic [7:0] cnt_inc;
    logic [8:0] err;
    logic [8:0] abs_err;
    logic       good_win;
    logic       vco_new;
    err_sign_e  sign_new;
    logic       same_sign;

    assign run = pll.pll_enable & pll.pll_reset_n & ~pll.pll_bypass_en & pll.pll_iso_n;

    serdesphy_sync_edge u_fb_sync (
        .clk      (clk_ref_24m),
        .rst      (rst),
        .async_in (fb_clk_div),
        .rise     (fb_rise)
    );

    // Window evaluation operates on the count including this cycle's pulse.
    assign cnt_inc   = (fb_rise && edge_q != 8'hFF) ? edge_q + 8'd1 : edge_q;
    assign err       = {1'b0, cnt_inc} - 9'(EXP_EDGES);
    assign abs_err   = err[8] ? (9'd0 - err) : err;
    assign good_win  = abs_err <= 9'(TOL);
    assign vco_new   = (cnt_inc >= 8'(VCO_MIN_EDGES)) && (cnt_inc <= 8'(VCO_MAX_EDGES));
    assign sign_new  = classify_err(err);
    assign same_sign = (sign_new != ERR_ON_TARGET) && (sign_new == sign_q);

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        win_d    = win_q;
        edge_d   = edge_q;
        good_d   = good_q;
        rail_d   = rail_q;
        lock_d   = lock_q;
        vco_d    = vco_q;
        cp_d     = cp_q;
        count_d  = count_q;
        sign_d   = sign_q;
        trim_d   = trim_q;
`ifdef PLL_LOCK_MON_HYST_EN
        bad_d    = bad_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d  = ST_SETTLE;
                    settle_d = '0;
                end
            end

            ST_SETTLE: begin
                if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_MEASURE;
                    win_d   = '0;
                    edge_d  = '0;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end

            ST_MEASURE: begin
                if (win_q == WIN_W'(WINDOW_CYCLES - 1)) begin
                    win_d   = '0;
                    edge_d  = '0;
                    count_d = cnt_inc;
                    sign_d  = sign_new;
                    vco_d   = vco_new;
                    trim_d  = pll.pll_vco_trim;

                    if (same_sign)
                        rail_d = (rail_q == RAIL_W'(CP_RAIL_WINDOWS)) ? rail_q : rail_q + RAIL_W'(1);
                    else
                        rail_d = (sign_new != ERR_ON_TARGET) ? RAIL_W'(1) : '0;

                    if (good_win) begin
                        good_d = (good_q == GOOD_W'(LOCK_WINDOWS)) ? good_q : good_q + GOOD_W'(1);
                        lock_d = lock_q | (good_d == GOOD_W'(LOCK_WINDOWS));
`ifdef PLL_LOCK_MON_HYST_EN
                        bad_d  = '0;
`endif
                    end else begin
                        good_d = '0;
`ifdef PLL_LOCK_MON_HYST_EN
                        // Lock survives one isolated bad window.
                        bad_d  = (bad_q == 2'd2) ? bad_q : bad_q + 2'd1;
                        lock_d = lock_q & (bad_d < 2'd2);
`else
                        lock_d = 1'b0;
`endif
                    end
                end else begin
                    win_d  = win_q + WIN_W'(1);
                    edge_d = cnt_inc;
                end

                // Pump-off is reflected every cycle, railing only at evaluations.
                cp_d = (rail_d < RAIL_W'(CP_RAIL_WINDOWS)) && (pll.pll_cp_current != 2'b00);
            end

            default: state_d = ST_IDLE;
        endcase

        if (!run) begin
            state_d  = ST_IDLE;
            settle_d = '0;
            win_d    = '0;
            edge_d   = '0;
            good_d   = '0;
            rail_d   = '0;
            lock_d   = 1'b0;
            vco_d    = 1'b1;
            cp_d     = 1'b1;
            count_d  = '0;
            sign_d   = ERR_ON_TARGET;
            trim_d   = '0;
`ifdef PLL_LOCK_MON_HYST_EN
            bad_d    = '0;
`endif
        end
    end

    always_ff @(posedge clk_ref_24m) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            win_q    <= '0;
            edge_q   <= '0;
            good_q   <= '0;
            rail_q   <= '0;
            lock_q   <= 1'b0;
            vco_q    <= 1'b1;
            cp_q     <= 1'b1;
            count_q  <= '0;
            sign_q   <= ERR_ON_TARGET;
            trim_q   <= '0;
`ifdef PLL_LOCK_MON_HYST_EN
            bad_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            win_q    <= win_d;
            edge_q   <= edge_d;
            good_q   <= good_d;
            rail_q   <= rail_d;
            lock_q   <= lock_d;
            vco_q    <= vco_d;
            cp_q     <= cp_d;
            count_q  <= count_d;
            sign_q   <= sign_d;
            trim_q   <= trim_d;
`ifdef PLL_LOCK_MON_HYST_EN
            bad_q    <= bad_d;
`endif
        end
    end

    assign pll.pll_lock_raw     = lock_q;
    assign pll.pll_vco_ok       = vco_q;
    assign pll.pll_cp_ok        = cp_q;
    assign pll.freq_count       = count_q;
    assign pll.freq_err_sign    = sign_q;
    assign pll.freq_status_trim = trim_q;

endmodule

// File: doc/serdesphy_pll_lock_monitor.md
Name: serdesphy_pll_lock_monitor

Overview:
Analog-side responder to the PLL controller. It consumes the controller's PLL enable, reset, bypass, isolation and trim controls, and measures the divided VCO feedback against the 24 MHz reference. From that measurement it produces the raw lock, VCO-range and charge-pump-health indications that the controller validates. It sits between the PLL macro's feedback divider and the controller's status inputs, and serves as the synthesizable lock detector and as the behavioural stand-in in top-level benches.

Parameters:
WINDOW_CYCLES, 240, reference cycles per measurement window (10 us)
EXP_EDGES, 30, expected feedback rising edges per window (fb = ref/8)
TOL, 1, allowed |count - EXP_EDGES| for a good window
LOCK_WINDOWS, 4, consecutive good windows before pll_lock_raw asserts
SETTLE_CYCLES, 48, wait after enable before the first window
VCO_MIN_EDGES, 15, lower bound of the VCO operating range
VCO_MAX_EDGES, 45, upper bound of the VCO operating range
CP_RAIL_WINDOWS, 3, consecutive same-sign nonzero errors that flag a railed charge pump

Ports:
clk_ref_24m  in  1  reference clock, sole clock
rst  in  1  synchronous, active-high reset
pll_enable  in  1  PLL enable from controller
pll_reset_n  in  1  PLL reset from controller, active-low
pll_bypass_en  in  1  bypass mode
pll_iso_n  in  1  isolation control (0 = isolated)
pll_vco_trim  in  4  VCO trim; sampled into freq_status only
pll_cp_current  in  2  charge-pump current select; 2'b00 = pump off
fb_clk_div  in  1  divided VCO feedback, asynchronous to clk_ref_24m
pll_lock_raw  out  1  raw frequency lock
pll_vco_ok  out  1  VCO within operating range
pll_cp_ok  out  1  charge pump not railed and not off
freq_count  out  8  edge count of the last completed window
freq_err_sign  out  2  2'b00 on target, 2'b01 fast, 2'b10 slow

Behaviour:
- Reset (rst=1 at a clock edge):
  - pll_lock_raw=0, pll_vco_ok=1, pll_cp_ok=1, freq_count=0, freq_err_sign=0.
  - All counters 0, state IDLE.
- Run condition: run = pll_enable & pll_reset_n & ~pll_bypass_en & pll_iso_n.
- fb_clk_div path: 2-flop synchronizer, then rising-edge detect into a one-cycle pulse. Latency from input edge to pulse is 3 cycles.
- States:
  - IDLE: outputs held at their reset values. Go to SETTLE when run=1.
  - SETTLE: count SETTLE_CYCLES. Edge pulses are ignored. Go to MEASURE at terminal count.
  - MEASURE:
    - win_cnt runs 0..WINDOW_CYCLES-1. edge_cnt is 8-bit and saturates at 255.
    - At win_cnt=WINDOW_CYCLES-1, the window is evaluated; a pulse arriving in that same cycle is included in the count.
    - The evaluation updates registered outputs, visible the next cycle. Next window starts with edge_cnt=0 (or 1 if an edge arrives in the first cycle).
  - Any state with run=0 goes to IDLE on the next edge. All outputs return to reset values there, including a drop mid-window.
- Window evaluation, with C = final count:
  - freq_count=C.
  - err = C - EXP_EDGES, computed signed in 9 bits.
  - good = |err| <= TOL.
  - freq_err_sign: 00 if err=0, 01 if err>0, 10 if err<0.
  - pll_vco_ok = (VCO_MIN_EDGES <= C <= VCO_MAX_EDGES).
  - good_cnt increments on a good window and saturates at LOCK_WINDOWS. pll_lock_raw=1 once good_cnt reaches LOCK_WINDOWS.
  - A bad window clears good_cnt and deasserts pll_lock_raw (subject to the optional feature).
  - rail_cnt increments when err is nonzero with the same sign as the previous window's err; otherwise it is set to 1 if err is nonzero, or 0 if err is zero.
  - pll_cp_ok = (rail_cnt < CP_RAIL_WINDOWS) & (pll_cp_current != 0).
- pll_cp_current=0 while in MEASURE drops pll_cp_ok on the next cycle, not at window end.
- pll_vco_ok and pll_cp_ok stay 1 until the first evaluation, so the controller does not take its error path during settling.
- freq_status for freq_count is frozen for the window; changing pll_vco_trim mid-window has no effect on the count logic.

Optional Feature:
PLL_LOCK_MON_HYST_EN
- Defined: pll_lock_raw deasserts only after 2 consecutive bad windows. A single bad window holds lock but still clears good_cnt.
- Undefined: one bad window deasserts pll_lock_raw at that evaluation.

Decomposition:
- Shared package serdesphy_pll_pkg: state encoding (IDLE/SETTLE/MEASURE), freq_err_sign encodings, default window, expected-edge and VCO bound constants.
- One sub-module, serdesphy_sync_edge: 2-flop synchronizer plus rising-edge pulse, reused for other asynchronous analog status inputs.

Test Plan:
1. Reset, then run=1 with fb period 8 cycles.
   - freq_count=30 at every window.
   - pll_lock_raw rises after the 4th window evaluation, about 48+960+3 cycles after run.
   - vco_ok=1, cp_ok=1 throughout.
2. fb period 7 cycles.
   - freq_count=34, freq_err_sign=01, vco_ok=1, lock_raw stays 0.
   - cp_ok drops at the 3rd window evaluation.
3. fb period 4 cycles: freq_count=60 and vco_ok=0 at the 1st evaluation.
4. fb held constant 0: freq_count=0, vco_ok=0, freq_err_sign=10.
5. Lock at period 8, then a single window at period 7.
   - Without the macro: lock_raw drops at that evaluation.
   - With the macro: lock_raw holds, then re-asserts at full lock 4 windows later.
6. Locked, then pll_bypass_en=1 mid-window: next cycle lock_raw=0, vco_ok=1, cp_ok=1, state IDLE. Same response for rst=1 mid-window.
